stream_arbiter_rr: RTL and testbench

Round-robin N-to-1 stream arbiter. It shares one downstream valid/ready consumer between SIZE upstream requesters, for example several Register/broadcast lanes feeding one shared compute unit or memory port. The output has one registered stage. Optional packet lock holds the grant on one source until its last beat.

---
 rtl/stream_pkg.sv | 22 ++
 rtl/stream_arbiter_rr_if.sv | 33 +++
 rtl/stream_arbiter_rr_pick.sv | 31 +++
 rtl/stream_arbiter_rr.sv | 121 ++++++++++++
 tb/tb_stream_arbiter_rr.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/stream_pkg.sv
// Shared types and helpers for the round-robin stream arbiter.
package stream_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam string LOCK_YES = "yes";
    localparam string LOCK_NO  = "no";

    // Ceiling log2 with a floor of 1 so a single requester still gets a 1-bit index.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((64'(1) << i) < 64'(n)) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/stream_arbiter_rr_if.sv
// Upstream request lanes plus the shared downstream valid/ready stream.
interface stream_arbiter_rr_if
    import stream_pkg::*;
#(
    parameter int SIZE  = 4,
    parameter int WIDTH = 32
);
    localparam int GW = clog2(SIZE);

    logic [SIZE-1:0]       up_valid;
    logic [SIZE-1:0]       up_ready;
    logic [SIZE*WIDTH-1:0] up_data;
    logic [SIZE-1:0]       up_last;

    logic                  dn_valid;
    logic                  dn_ready;
    logic [WIDTH-1:0]      dn_data;
    logic                  dn_last;
    logic [GW-1:0]         dn_grant;

    // Environment side: drives the requesters and the downstream ready.
    modport master (
        output up_valid, up_data, up_last, dn_ready,
        input  up_ready, dn_valid, dn_data, dn_last, dn_grant
    );

    // Arbiter side.
    modport slave (
        input  up_valid, up_data, up_last, dn_ready,
        output up_ready, dn_valid, dn_data, dn_last, dn_grant
    );

endinterface

// File: rtl/stream_arbiter_rr_pick.sv
// Combinational round-robin search: first valid requester starting at ptr, wrapping mod SIZE.
module stream_arbiter_rr_pick
    import stream_pkg::*;
#(
    parameter int SIZE = 4,
    parameter int GW   = clog2(SIZE)
) (
    input  logic [SIZE-1:0] valid,
    input  logic [GW-1:0]   ptr,
    output logic [GW-1:0]   sel,
    output logic            found
);

    int idx;

    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        for (int j = 0; j < SIZE; j++) begin
            // Explicit wrap instead of modulo on GW bits so non-power-of-two SIZE works.
            idx = int'(ptr) + j;
            if (idx >= SIZE) idx = idx - SIZE;
            if (!found && valid[idx]) begin
                found = 1'b1;
                sel   = idx[GW-1:0];
            end
        end
    end

endmodule

// File: rtl/stream_arbiter_rr.sv
// Round-robin N-to-1 stream arbiter with one registered output stage and optional packet lock.
//
//  state  | meaning
//  -------+--------------------------------------------------------------
//  ARB    | grant moves round-robin from ptr among valid requesters
//  LOCKED | grant held on lk until its last beat transfers
module stream_arbiter_rr
    import stream_pkg::*;
#(
    parameter int    SIZE  = 4,
    parameter int    WIDTH = 32,
    parameter string LOCK  = LOCK_NO
) (
    input  logic                clk,
    input  logic                rst,
    stream_arbiter_rr_if.slave  bus
);

    localparam int GW      = clog2(SIZE);
    localparam bit LOCK_EN = (LOCK == LOCK_YES);

    arb_state_t       state_q, state_d;
    logic [GW-1:0]    ptr_q, ptr_d;
    logic [GW-1:0]    lk_q, lk_d;

    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic             last_q;
    logic [GW-1:0]    grant_q;

    logic [GW-1:0]    pick_sel;
    logic             pick_found;
    logic [GW-1:0]    sel;
    logic             any_req;
    logic             wrdy;
    logic [SIZE-1:0]  ready;
    logic             take;
    logic [WIDTH-1:0] sel_data;
    logic             sel_last;

    stream_arbiter_rr_pick #(
        .SIZE (SIZE),
        .GW   (GW)
    ) u_pick (
        .valid (bus.up_valid),
        .ptr   (ptr_q),
        .sel   (pick_sel),
        .found (pick_found)
    );

    assign wrdy = !valid_q || bus.dn_ready;

    always_comb begin
        sel      = pick_sel;
        any_req  = pick_found;
        ready    = '0;
        take     = 1'b0;
        sel_data = bus.up_data[int'(sel)*WIDTH +: WIDTH];
        sel_last = 1'b0;
        if (state_q == LOCKED) begin
            sel      = lk_q;
            any_req  = 1'b1;
            sel_data = bus.up_data[int'(lk_q)*WIDTH +: WIDTH];
        end
        if (LOCK_EN) sel_last = bus.up_last[sel];
        // Reset also blocks ready so no requester sees a phantom handshake.
        if (wrdy && any_req && !rst) ready[sel] = 1'b1;
        take = ready[sel] && bus.up_valid[sel];
    end

    assign bus.up_ready = ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        lk_d    = lk_q;
        if (take) begin
            if (!LOCK_EN || sel_last) begin
                ptr_d   = (sel == GW'(SIZE - 1)) ? '0 : sel + 1'b1;
                state_d = ARB;
            end else if (state_q == ARB) begin
                state_d = LOCKED;
                lk_d    = sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB;
            ptr_q   <= '0;
            lk_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lk_q    <= lk_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            grant_q <= '0;
        end else if (take) begin
            valid_q <= 1'b1;
            data_q  <= sel_data;
            last_q  <= sel_last;
            grant_q <= sel;
        end else if (bus.dn_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.dn_valid = valid_q;
    assign bus.dn_data  = data_q;
    assign bus.dn_last  = last_q;
    assign bus.dn_grant = grant_q;

endmodule

// File: tb/tb_stream_arbiter_rr.sv
// Directed bench: round-robin order, backpressure, packet lock, wrap skip and reset mid-packet.
module tb_stream_arbiter_rr;
    import stream_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stream_arbiter_rr_if #(.SIZE(3), .WIDTH(8)) bus_a ();
    stream_arbiter_rr_if #(.SIZE(3), .WIDTH(8)) bus_b ();
    stream_arbiter_rr_if #(.SIZE(4), .WIDTH(8)) bus_c ();

    stream_arbiter_rr #(.SIZE(3), .WIDTH(8), .LOCK(LOCK_NO))  u_a (.clk(clk), .rst(rst), .bus(bus_a));
    stream_arbiter_rr #(.SIZE(3), .WIDTH(8), .LOCK(LOCK_YES)) u_b (.clk(clk), .rst(rst), .bus(bus_b));
    stream_arbiter_rr #(.SIZE(4), .WIDTH(8), .LOCK(LOCK_NO))  u_c (.clk(clk), .rst(rst), .bus(bus_c));

    int errors = 0;
    int checks = 0;
    int cnt_a[3];
    logic [2:0] hs_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_data_a();
        for (int i = 0; i < 3; i++) bus_a.up_data[i*8 +: 8] = 8'((i + 1) * 16 + cnt_a[i]);
    endtask

    // Advance one clock; bus_a sources bump their counters on an accepted beat.
    task automatic tick();
        hs_a = bus_a.up_valid & bus_a.up_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) if (hs_a[i]) cnt_a[i]++;
        set_data_a();
    endtask

    initial begin
        for (int i = 0; i < 3; i++) cnt_a[i] = 0;
        rst = 1'b1;
        bus_a.up_valid = 3'b111; bus_a.up_last = 3'b111; bus_a.dn_ready = 1'b1;
        set_data_a();
        bus_b.up_valid = 3'b111; bus_b.up_last = 3'b000; bus_b.dn_ready = 1'b1;
        bus_b.up_data  = {8'hB2, 8'hB1, 8'hB0};
        bus_c.up_valid = 4'b1111; bus_c.up_last = 4'b0000; bus_c.dn_ready = 1'b1;
        bus_c.up_data  = {8'hC3, 8'hC2, 8'hC1, 8'hC0};

        // Reset held two cycles with every source valid
        for (int r = 0; r < 2; r++) begin
            tick();
            chk("rst_valid_a", 32'(bus_a.dn_valid), 32'd0);
            chk("rst_ready_a", 32'(bus_a.up_ready), 32'd0);
            chk("rst_grant_a", 32'(bus_a.dn_grant), 32'd0);
            chk("rst_data_a",  32'(bus_a.dn_data),  32'd0);
            chk("rst_ready_b", 32'(bus_b.up_ready), 32'd0);
        end
        rst = 1'b0;
        bus_b.up_valid = 3'b000;
        bus_c.up_valid = 4'b0000;
        #1;
        chk("first_ready_a", 32'(bus_a.up_ready), 32'b001);

        // All valid, no lock: 0,1,2,0,1,2,0 with no bubbles; last input ignored
        for (int k = 0; k < 7; k++) begin
            tick();
            chk("rr_valid", 32'(bus_a.dn_valid), 32'd1);
            chk("rr_grant", 32'(bus_a.dn_grant), 32'(k % 3));
            chk("rr_data",  32'(bus_a.dn_data),  32'((k % 3 + 1) * 16 + k / 3));
            chk("rr_last",  32'(bus_a.dn_last),  32'd0);
        end

        // Backpressure with output full
        bus_a.dn_ready = 1'b0;
        #1;
        chk("bp_ready0", 32'(bus_a.up_ready), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("bp_valid", 32'(bus_a.dn_valid), 32'd1);
            chk("bp_data",  32'(bus_a.dn_data),  32'h12);
            chk("bp_grant", 32'(bus_a.dn_grant), 32'd0);
            chk("bp_ready", 32'(bus_a.up_ready), 32'd0);
        end
        bus_a.dn_ready = 1'b1;
        #1;
        chk("bp_rel_ready", 32'(bus_a.up_ready), 32'b010);
        tick();
        chk("bp_rel_grant", 32'(bus_a.dn_grant), 32'd1);
        chk("bp_rel_data",  32'(bus_a.dn_data),  32'h22);
        bus_a.up_valid = 3'b000;
        tick();
        chk("drain_valid", 32'(bus_a.dn_valid), 32'd0);
        chk("drain_data",  32'(bus_a.dn_data),  32'h22);

        // Lock: single beat from 0 moves ptr to 1, then 3-beat packet from 1
        bus_b.up_valid = 3'b001; bus_b.up_last = 3'b001;
        #1;
        chk("lk_pre_ready", 32'(bus_b.up_ready), 32'b001);
        tick();
        chk("lk_pre_grant", 32'(bus_b.dn_grant), 32'd0);
        chk("lk_pre_last",  32'(bus_b.dn_last),  32'd1);
        bus_b.up_valid = 3'b111; bus_b.up_last = 3'b101;
        #1;
        chk("lk_ready1", 32'(bus_b.up_ready), 32'b010);
        tick();
        chk("lk_b1_grant", 32'(bus_b.dn_grant), 32'd1);
        chk("lk_b1_data",  32'(bus_b.dn_data),  32'hB1);
        chk("lk_b1_last",  32'(bus_b.dn_last),  32'd0);
        chk("lk_ready2",   32'(bus_b.up_ready), 32'b010);
        tick();
        chk("lk_b2_grant", 32'(bus_b.dn_grant), 32'd1);
        chk("lk_b2_valid", 32'(bus_b.dn_valid), 32'd1);
        bus_b.up_valid = 3'b101;
        #1;
        chk("lk_idle_ready", 32'(bus_b.up_ready), 32'b010);
        tick();
        chk("lk_idle_valid1", 32'(bus_b.dn_valid), 32'd0);
        chk("lk_idle_ready1", 32'(bus_b.up_ready), 32'b010);
        tick();
        chk("lk_idle_valid2", 32'(bus_b.dn_valid), 32'd0);
        bus_b.up_valid = 3'b111; bus_b.up_last = 3'b111;
        #1;
        chk("lk_ready3", 32'(bus_b.up_ready), 32'b010);
        tick();
        chk("lk_b3_grant", 32'(bus_b.dn_grant), 32'd1);
        chk("lk_b3_last",  32'(bus_b.dn_last),  32'd1);
        chk("lk_after_ready", 32'(bus_b.up_ready), 32'b100);
        tick();
        chk("lk_next_grant", 32'(bus_b.dn_grant), 32'd2);
        chk("lk_next_data",  32'(bus_b.dn_data),  32'hB2);
        bus_b.up_valid = 3'b000;
        tick();

        // Sparse requests with wrap: push ptr to 3, then only source 1 valid
        bus_c.up_valid = 4'b0100;
        #1;
        chk("sp_ready2", 32'(bus_c.up_ready), 32'b0100);
        tick();
        chk("sp_grant2", 32'(bus_c.dn_grant), 32'd2);
        bus_c.up_valid = 4'b0010;
        #1;
        chk("sp_wrap_ready", 32'(bus_c.up_ready), 32'b0010);
        tick();
        chk("sp_wrap_grant", 32'(bus_c.dn_grant), 32'd1);
        chk("sp_wrap_data",  32'(bus_c.dn_data),  32'hC1);
        bus_c.up_valid = 4'b1111;
        #1;
        chk("sp_ptr2_ready", 32'(bus_c.up_ready), 32'b0100);
        tick();
        chk("sp_ptr2_grant", 32'(bus_c.dn_grant), 32'd2);
        bus_c.up_valid = 4'b0000;

        // Reset while locked on source 2
        bus_b.up_valid = 3'b100; bus_b.up_last = 3'b000;
        #1;
        chk("mr_ready", 32'(bus_b.up_ready), 32'b100);
        tick();
        chk("mr_grant", 32'(bus_b.dn_grant), 32'd2);
        bus_b.up_valid = 3'b111;
        #1;
        chk("mr_locked_ready", 32'(bus_b.up_ready), 32'b100);
        rst = 1'b1;
        #1;
        chk("mr_rst_ready", 32'(bus_b.up_ready), 32'b000);
        tick();
        chk("mr_rst_valid", 32'(bus_b.dn_valid), 32'd0);
        chk("mr_rst_grant", 32'(bus_b.dn_grant), 32'd0);
        rst = 1'b0;
        #1;
        chk("mr_arb_ready", 32'(bus_b.up_ready), 32'b001);
        tick();
        chk("mr_arb_grant", 32'(bus_b.dn_grant), 32'd0);
        chk("mr_arb_data",  32'(bus_b.dn_data),  32'hB0);
        chk("mr_arb_valid", 32'(bus_b.dn_valid), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
